// File: rtl/ram_ctrl_pkg.sv
// Shared constants and FSM state encoding for the two-client RAM arbiter.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way grant select. Round-robin on rr_last by default;
// RAM_ARB_FIXED_PRIO_EN makes client 0 win every tie and drops the pointer input.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  logic i_rr_last,
`endif
  output logic o_gnt0_c,
  output logic o_gnt1_c
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign o_gnt0_c = i_req0;
  assign o_gnt1_c = i_req1 & ~i_req0;
`else
  // On a tie the client that did not win last time is favoured
  assign o_gnt0_c = i_req0 & (~i_req1 | i_rr_last);
  assign o_gnt1_c = i_req1 & (~i_req0 | ~i_rr_last);
`endif

endmodule

// File: rtl/ram_arb2.sv
// Two-requester arbiter/sequencer for the single-port 256x8 synchronous SRAM.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (client 0) instead of round-robin.
module ram_arb2
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t r_state;
  logic   r_sel;
  logic   w_gnt0_c;
  logic   w_gnt1_c;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic r_rr_last;
`endif

  rr_arb2 u_arb (
    .i_req0    (req0),
    .i_req1    (req1),
`ifndef RAM_ARB_FIXED_PRIO_EN
    .i_rr_last (r_rr_last),
`endif
    .o_gnt0_c  (w_gnt0_c),
    .o_gnt1_c  (w_gnt1_c)
  );

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Last winner; reset to 1 so client 0 takes the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= 1'b1;
    end else if (r_state == IDLE && (w_gnt0_c || w_gnt1_c)) begin
      r_rr_last <= w_gnt1_c;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt0_c || w_gnt1_c) begin
            ram_cs   <= 1'b1;
            ram_we   <= w_gnt1_c ? we1    : we0;
            ram_addr <= w_gnt1_c ? addr1  : addr0;
            ram_din  <= w_gnt1_c ? wdata1 : wdata0;
            gnt0     <= w_gnt0_c;
            gnt1     <= w_gnt1_c;
            r_sel    <= w_gnt1_c;
            r_state  <= ACC;
          end
        end
        ACC: begin
          // RAM samples the pins at this edge; address and data hold afterwards
          ram_cs  <= 1'b0;
          ram_we  <= 1'b0;
          r_state <= ram_we ? IDLE : RD_WAIT;
        end
        RD_WAIT: begin
          rdata   <= ram_dout;
          rvalid0 <= ~r_sel;
          rvalid1 <= r_sel;
          r_state <= RESP;
        end
        RESP: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb2.sv
// Directed self-checking bench for ram_arb2 with a behavioural 256x8 synchronous RAM.
module tb_ram_arb2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic       ram_cs, ram_we;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arb2 #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // RAM model: registered read, junk on dout whenever no read was issued
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= (ram_cs && !ram_we) ? mem[ram_addr] : 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({gnt0, gnt1, rvalid0, rvalid1, rdata, ram_cs, ram_we, ram_addr, ram_din});
  endfunction

  task automatic wait_gnt(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        who = gnt1 ? 1 : 0;
        break;
      end
    end
    if (who < 0) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive(input int c, input bit r, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (c == 0) begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  // Single uncontended transaction with full timing checks
  task automatic xact(input int c, input bit we, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd);
    int who;
    drive(c, 1'b1, we, a, d);
    wait_gnt(who);
    check("xact_who", 32'(who), 32'(c));
    drive(c, 1'b0, 1'b0, 8'h00, 8'h00);
    check("xact_cs", 32'(ram_cs), 32'd1);
    check("xact_we", 32'(ram_we), 32'(we));
    check("xact_addr", 32'(ram_addr), 32'(a));
    if (we) check("xact_din", 32'(ram_din), 32'(d));
    @(negedge clk);
    check("xact_cs_drop", 32'(ram_cs), 32'd0);
    if (!we) begin
      check("xact_rv_early", 32'({rvalid0, rvalid1}), 32'd0);
      @(negedge clk);
      check("xact_rv", 32'({rvalid0, rvalid1}), (c == 0) ? 32'd2 : 32'd1);
      check("xact_rdata", 32'(rdata), 32'(exp_rd));
      @(negedge clk);
      check("xact_rv_pulse", 32'({rvalid0, rvalid1}), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int who;
    int exp_who;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset with a pending request
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_gnt", 32'({gnt0, gnt1}), 32'd2);
    check("rst_rel_cs", 32'(ram_cs), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check("rst_rel_gnt_pulse", 32'(gnt0), 32'd0);
    check("rst_rel_cs_pulse", 32'(ram_cs), 32'd0);
    repeat (3) @(negedge clk);

    // Single write then read, plus preload for contention
    xact(0, 1'b1, 8'h80, 8'h61, 8'h00);
    xact(0, 1'b0, 8'h80, 8'h00, 8'h61);
    xact(0, 1'b1, 8'h10, 8'h11, 8'h00);
    xact(1, 1'b1, 8'h20, 8'h22, 8'h00);

    // Reset during RD_WAIT of a client 1 read
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    wait_gnt(who);
    check("midrst_who", 32'(who), 32'd1);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrst_outs", all_outs(), 32'd0);
    @(negedge clk);
    check("midrst_no_rv", 32'({rvalid0, rvalid1}), 32'd0);
    @(negedge clk);
    check("midrst_no_rv2", 32'({rvalid0, rvalid1}), 32'd0);
    rst_n = 1'b1;

    // Contention: both reading continuously
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_who = 0;
`else
      exp_who = k % 2;
`endif
      wait_gnt(who);
      check("cont_who", 32'(who), 32'(exp_who));
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      repeat (2) @(negedge clk);
      check("cont_rv", 32'({rvalid0, rvalid1}), (exp_who == 0) ? 32'd2 : 32'd1);
      check("cont_rdata", 32'(rdata), (exp_who == 0) ? 32'h11 : 32'h22);
    end
    @(negedge clk);

    // Mixed: client 0 writes while client 1 reads the same address
    drive(0, 1'b1, 1'b1, 8'h81, 8'h62);
    drive(1, 1'b1, 1'b0, 8'h81, 8'h00);
    wait_gnt(who);
    check("mixed_first", 32'(who), 32'd0);
    check("mixed_we", 32'(ram_we), 32'd1);
    check("mixed_din", 32'(ram_din), 32'h62);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_gnt(who);
    check("mixed_second", 32'(who), 32'd1);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("mixed_rv", 32'({rvalid0, rvalid1}), 32'd1);
    check("mixed_rdata", 32'(rdata), 32'h62);
    @(negedge clk);

    // Idle: RAM never selected, rdata holds despite junk on ram_dout
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_cs", 32'(ram_cs), 32'd0);
      check("idle_rdata", 32'(rdata), 32'h62);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
